// File: rtl/axi_arb_pkg.sv
// Shared types and AXI response codes for the cache-side AXI request arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_req_arbiter_rr_pick.sv
// Combinational round-robin selector: the search starts just after the last
// grant and wraps, so the previous winner has the lowest priority.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_last,
  output logic [$clog2(N)-1:0] o_grant,
  output logic                 o_any
);

  localparam int IDW = $clog2(N);

  int   w_idx;
  logic w_found;

  always_comb begin
    o_grant = i_last;
    o_any   = |i_req;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = int'(i_last) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && i_req[w_idx[IDW-1:0]]) begin
        o_grant = w_idx[IDW-1:0];
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_req_arbiter.sv
// Shares one single-outstanding AXI master driver between NUM_REQ requesters,
// routing command, write beats, read beats and completion to the current owner.
//
// state | meaning
// IDLE  | no owner; round-robin arbitration among valid requesters
// ISSUE | owner's command presented to the driver, waiting for drv_req_ready
// BUSY  | beats routed to/from owner until drv_done or watchdog expiry
module axi_req_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        M_AXI_ACLK,
  input  logic                        M_AXI_ARESET,

  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_is_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*8-1:0]        req_len,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]          req_wvalid,
  output logic [NUM_REQ-1:0]          req_wready,

  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [NUM_REQ-1:0]          rsp_rvalid,
  output logic [NUM_REQ-1:0]          rsp_done,
  output logic [NUM_REQ-1:0]          rsp_err,

  output logic                        drv_req_valid,
  input  logic                        drv_req_ready,
  output logic                        drv_is_write,
  output logic [ADDR_W-1:0]           drv_addr,
  output logic [7:0]                  drv_len,
  output logic [DATA_W-1:0]           drv_wdata,
  output logic                        drv_wvalid,
  input  logic                        drv_wready,
  input  logic [DATA_W-1:0]           drv_rdata,
  input  logic                        drv_rvalid,
  input  logic                        drv_done,
  input  logic [1:0]                  drv_resp,

  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  arb_state_t       r_state,       w_state_nxt;
  logic [IDW-1:0]   r_owner,       w_owner_nxt;
  logic [IDW-1:0]   r_last,        w_last_nxt;
  logic [WD_W-1:0]  r_wd_cnt,      w_wd_cnt_nxt;
  logic             r_timeout_err, w_timeout_err_nxt;

  logic [IDW-1:0]     w_pick;
  logic               w_any;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic               w_wd_expired;

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_last  (r_last),
    .o_grant (w_pick),
    .o_any   (w_any)
  );

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_state       <= IDLE;
      r_owner       <= '0;
      r_last        <= IDW'(NUM_REQ - 1);
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner       <= w_owner_nxt;
      r_last        <= w_last_nxt;
      r_wd_cnt      <= w_wd_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign w_owner_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_wd_expired = (TIMEOUT_CYCLES > 0) && (r_state == BUSY) && (r_wd_cnt == WD_LIMIT);

  always_comb begin
    w_state_nxt       = r_state;
    w_owner_nxt       = r_owner;
    w_last_nxt        = r_last;
    w_wd_cnt_nxt      = r_wd_cnt;
    w_timeout_err_nxt = r_timeout_err;
    req_ready         = '0;
    req_wready        = '0;
    rsp_rvalid        = '0;
    rsp_done          = '0;
    rsp_err           = '0;
    drv_req_valid     = 1'b0;
    drv_wvalid        = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_owner_nxt = w_pick;
          w_state_nxt = ISSUE;
        end
      end

      ISSUE: begin
        drv_req_valid = 1'b1;
        if (drv_req_ready) begin
          req_ready    = w_owner_oh;
          w_wd_cnt_nxt = '0;
          w_state_nxt  = BUSY;
        end
      end

      BUSY: begin
        drv_wvalid = req_wvalid[r_owner];
        if (drv_wready) req_wready = w_owner_oh;
        if (drv_rvalid) rsp_rvalid = w_owner_oh;
        if (r_wd_cnt != WD_LIMIT) w_wd_cnt_nxt = r_wd_cnt + WD_W'(1);
        // A real completion in the expiry cycle takes precedence over the abort.
        if (drv_done) begin
          rsp_done    = w_owner_oh;
          rsp_err     = (drv_resp != RESP_OKAY) ? w_owner_oh : '0;
          w_last_nxt  = r_owner;
          w_state_nxt = IDLE;
        end else if (w_wd_expired) begin
          rsp_done          = w_owner_oh;
          rsp_err           = w_owner_oh;
          w_timeout_err_nxt = 1'b1;
          w_last_nxt        = r_owner;
          w_state_nxt       = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign drv_is_write = req_is_write[r_owner];
  assign drv_addr     = req_addr[r_owner*ADDR_W +: ADDR_W];
  assign drv_len      = req_len[r_owner*8 +: 8];
  assign drv_wdata    = req_wdata[r_owner*DATA_W +: DATA_W];
  assign rsp_rdata    = drv_rdata;

  assign grant_id    = r_owner;
  assign busy        = (r_state != IDLE);
  assign timeout_err = r_timeout_err;

endmodule
